// File: rtl/threshold_scan_sequencer.sv
// Threshold-scan (S-curve) sequencer: steps a signed discriminator threshold, lets it settle,
// counts trigger rising edges over a dwell window and streams each (threshold, count) result.
module threshold_scan_sequencer #(
  parameter int N_P     = 12,
  parameter int DWELL_W = 24,
  parameter int CNT_W   = 16,
  parameter int SET_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [N_P-1:0]     thr_start,
  input  logic [N_P-1:0]     thr_stop,
  input  logic [N_P-2:0]     thr_step,
  input  logic [SET_W-1:0]   settle_cycles,
  input  logic [DWELL_W-1:0] dwell_cycles,
  input  logic               trigger,
  output logic [N_P-1:0]     threshold,
  output logic               busy,
  output logic               done,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [N_P-1:0]     res_threshold,
  output logic [CNT_W-1:0]   res_count,
  output logic               res_sat
);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    DWELL,
    REPORT,
    DONE
  } state_t;

  localparam logic [N_P:0]     MaxPos = {2'b00, {(N_P-1){1'b1}}};
  localparam logic [CNT_W-1:0] CntMax = '1;

  state_t             state_q;
  logic [N_P-1:0]     stop_q;
  logic [N_P-2:0]     step_q;
  logic [SET_W-1:0]   settle_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [SET_W-1:0]   settleCnt_q;
  logic [DWELL_W-1:0] dwellCnt_q;
  logic [CNT_W-1:0]   trigCnt_q;
  logic               trigger_q;
  logic [N_P-1:0]     threshold_q;
  logic               busy_q;
  logic               done_q;
  logic               resValid_q;
  logic [N_P-1:0]     resThreshold_q;
  logic [CNT_W-1:0]   resCount_q;
  logic               resSat_q;

  logic               trigEdge;
  logic [CNT_W-1:0]   cnt_d;
  logic               cntSat;
  logic [N_P-2:0]     stepEff;
  logic [N_P:0]       next_d;
  logic               lastPoint;

  // Count includes the edge seen in the current DWELL cycle so the final cycle is not lost
  assign trigEdge = trigger & ~trigger_q;
  assign cnt_d    = (trigEdge && (trigCnt_q != CntMax)) ? trigCnt_q + 1'b1 : trigCnt_q;
  assign cntSat   = (cnt_d == CntMax);

  // Next threshold is formed one bit wider so positive overflow is caught instead of wrapping
  assign stepEff   = (step_q == '0) ? {{(N_P-2){1'b0}}, 1'b1} : step_q;
  assign next_d    = {threshold_q[N_P-1], threshold_q} + {2'b00, stepEff};
  assign lastPoint = ($signed(next_d) > $signed({stop_q[N_P-1], stop_q})) ||
                     ($signed(next_d) > $signed(MaxPos));

  function automatic logic [DWELL_W-1:0] dwellLoad(input logic [DWELL_W-1:0] cycles);
    return (cycles == '0) ? '0 : cycles - 1'b1;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      stop_q         <= '0;
      step_q         <= '0;
      settle_q       <= '0;
      dwell_q        <= '0;
      settleCnt_q    <= '0;
      dwellCnt_q     <= '0;
      trigCnt_q      <= '0;
      trigger_q      <= 1'b0;
      threshold_q    <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      resValid_q     <= 1'b0;
      resThreshold_q <= '0;
      resCount_q     <= '0;
      resSat_q       <= 1'b0;
    end else begin
      trigger_q <= trigger;
      done_q    <= 1'b0;
      // Abort outranks everything else, including a handshake in the same cycle
      if (abort && (state_q != IDLE)) begin
        state_q    <= IDLE;
        busy_q     <= 1'b0;
        resValid_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start && !abort) begin
              stop_q      <= thr_stop;
              step_q      <= thr_step;
              settle_q    <= settle_cycles;
              dwell_q     <= dwell_cycles;
              threshold_q <= thr_start;
              busy_q      <= 1'b1;
              if (settle_cycles != '0) begin
                state_q     <= SETTLE;
                settleCnt_q <= settle_cycles - 1'b1;
              end else begin
                state_q    <= DWELL;
                dwellCnt_q <= dwellLoad(dwell_cycles);
                trigCnt_q  <= '0;
              end
            end
          end
          SETTLE: begin
            if (settleCnt_q == '0) begin
              state_q    <= DWELL;
              dwellCnt_q <= dwellLoad(dwell_q);
              trigCnt_q  <= '0;
            end else begin
              settleCnt_q <= settleCnt_q - 1'b1;
            end
          end
          DWELL: begin
            trigCnt_q <= cnt_d;
            if (dwellCnt_q == '0) begin
              state_q        <= REPORT;
              resValid_q     <= 1'b1;
              resThreshold_q <= threshold_q;
              resCount_q     <= cnt_d;
              resSat_q       <= cntSat;
            end else begin
              dwellCnt_q <= dwellCnt_q - 1'b1;
            end
          end
          REPORT: begin
            if (res_ready) begin
              resValid_q <= 1'b0;
              if (lastPoint) begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end else begin
                threshold_q <= next_d[N_P-1:0];
                if (settle_q != '0) begin
                  state_q     <= SETTLE;
                  settleCnt_q <= settle_q - 1'b1;
                end else begin
                  state_q    <= DWELL;
                  dwellCnt_q <= dwellLoad(dwell_q);
                  trigCnt_q  <= '0;
                end
              end
            end
          end
          DONE: begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign threshold     = threshold_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign res_valid     = resValid_q;
  assign res_threshold = resThreshold_q;
  assign res_count     = resCount_q;
  assign res_sat       = resSat_q;

endmodule

// File: tb/tb_threshold_scan_sequencer.sv
// Bench for threshold_scan_sequencer: an elapsed-time scan model plus a trigger history log
// predicts every output; two instances (16-bit and 4-bit counters) share one stimulus.
module tb_threshold_scan_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [11:0] thrStart = '0;
  logic [11:0] thrStop = '0;
  logic [10:0] thrStep = '0;
  logic [7:0]  settleCycles = '0;
  logic [23:0] dwellCycles = '0;
  logic        trigger = 1'b0;
  logic        resReady = 1'b0;

  logic [11:0] threshold, resThreshold, thresholdB, resThresholdB;
  logic        busy, done, resValid, resSat;
  logic        busyB, doneB, resValidB, resSatB;
  logic [15:0] resCount;
  logic [3:0]  resCountB;

  int checks = 0;
  int errors = 0;
  int trigMode = 0;
  int readyMode = 0;
  int tbCyc = 0;
  int doneCnt = 0;
  bit compareOn = 0;

  typedef struct {
    int thr;
    int cnt;
    int sat;
    int cntB;
    int satB;
  } result_t;
  result_t resQ[$];

  threshold_scan_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .thr_start(thrStart), .thr_stop(thrStop), .thr_step(thrStep),
    .settle_cycles(settleCycles), .dwell_cycles(dwellCycles), .trigger(trigger),
    .threshold(threshold), .busy(busy), .done(done), .res_valid(resValid),
    .res_ready(resReady), .res_threshold(resThreshold), .res_count(resCount), .res_sat(resSat)
  );

  threshold_scan_sequencer #(.CNT_W(4)) dutSat (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .thr_start(thrStart), .thr_stop(thrStop), .thr_step(thrStep),
    .settle_cycles(settleCycles), .dwell_cycles(dwellCycles), .trigger(trigger),
    .threshold(thresholdB), .busy(busyB), .done(doneB), .res_valid(resValidB),
    .res_ready(resReady), .res_threshold(resThresholdB), .res_count(resCountB), .res_sat(resSatB)
  );

  always #5 clk = ~clk;

  // Behavioural scan model: time elapsed since the current point began decides the phase
  bit hist [0:65535];
  int cyc = 0;
  int firstCyc = 0;
  bit mActive = 0;
  bit mFinish = 0;
  int mStop, mStep, mSettle, mDwell, mElapsed;
  bit expBusy = 0, expDone = 0, expValid = 0;
  int expThr = 0, expResThr = 0, expRaw = 0;

  function automatic int countEdges(input int lastCyc, input int len);
    int n = 0;
    for (int c = lastCyc - len + 1; c <= lastCyc; c++) begin
      if (hist[c] && (c == firstCyc || !hist[c-1])) n++;
    end
    return n;
  endfunction

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      mActive = 0; mFinish = 0; expBusy = 0; expDone = 0; expValid = 0;
      expThr = 0; expResThr = 0; expRaw = 0; firstCyc = cyc;
    end else begin
      hist[cyc] = trigger;
      if (mFinish) begin
        mFinish = 0; expDone = 0; expBusy = 0;
      end else if (!mActive) begin
        if (start && !abort) begin
          mActive = 1; expBusy = 1; mElapsed = 0;
          expThr  = int'($signed(thrStart));
          mStop   = int'($signed(thrStop));
          mStep   = (thrStep == 0) ? 1 : int'(thrStep);
          mSettle = int'(settleCycles);
          mDwell  = (dwellCycles == 0) ? 1 : int'(dwellCycles);
        end
      end else if (abort) begin
        mActive = 0; expBusy = 0; expValid = 0;
      end else if (expValid) begin
        if (resReady) begin
          expValid = 0;
          if (expThr + mStep > mStop || expThr + mStep > 2047) begin
            mActive = 0; mFinish = 1; expDone = 1;
          end else begin
            expThr = expThr + mStep; mElapsed = 0;
          end
        end
      end else begin
        mElapsed++;
        if (mElapsed == mSettle + mDwell) begin
          expValid = 1; expResThr = expThr; expRaw = countEdges(cyc, mDwell);
        end
      end
      if (cyc < 65535) cyc++;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model
  initial forever begin
    @(negedge clk);
    if (compareOn) begin
      checkOutput("busy", int'(busy), int'(expBusy));
      checkOutput("done", int'(done), int'(expDone));
      checkOutput("resValid", int'(resValid), int'(expValid));
      checkOutput("threshold", int'($signed(threshold)), expThr);
      checkOutput("busyB", int'(busyB), int'(expBusy));
      checkOutput("doneB", int'(doneB), int'(expDone));
      checkOutput("resValidB", int'(resValidB), int'(expValid));
      checkOutput("thresholdB", int'($signed(thresholdB)), expThr);
      if (expValid) begin
        checkOutput("resThreshold", int'($signed(resThreshold)), expResThr);
        checkOutput("resCount", int'(resCount), (expRaw > 65535) ? 65535 : expRaw);
        checkOutput("resSat", int'(resSat), int'(expRaw >= 65535));
        checkOutput("resThresholdB", int'($signed(resThresholdB)), expResThr);
        checkOutput("resCountB", int'(resCountB), (expRaw > 15) ? 15 : expRaw);
        checkOutput("resSatB", int'(resSatB), int'(expRaw >= 15));
      end
    end
  end

  // Record accepted results and done pulses for the directed literal checks
  initial forever begin
    @(negedge clk);
    if (reset && resValid && resReady && !abort) begin
      resQ.push_back('{int'($signed(resThreshold)), int'(resCount), int'(resSat),
                       int'(resCountB), int'(resSatB)});
    end
    if (done) doneCnt++;
  end

  initial forever begin
    @(posedge clk); #2;
    case (trigMode)
      1:       trigger = (tbCyc % 4 == 0);
      2:       trigger = ~trigger;
      3:       trigger = 1'($urandom_range(0, 1));
      default: trigger = 1'b0;
    endcase
    case (readyMode)
      1:       resReady = 1'b0;
      2:       resReady = ($urandom_range(0, 3) != 0);
      default: resReady = 1'b1;
    endcase
    tbCyc++;
  end

  task automatic scrambleConfig();
    int base;
    base = ($urandom_range(0, 7) == 0) ? 2035 + int'($urandom_range(0, 12))
                                       : int'($urandom_range(0, 40)) - 20;
    thrStart     = 12'(base);
    thrStop      = 12'(base + int'($urandom_range(0, 30)) - 5);
    thrStep      = 11'($urandom_range(0, 6));
    settleCycles = 8'($urandom_range(0, 4));
    dwellCycles  = 24'($urandom_range(0, 12));
  endtask

  task automatic applyStimulus(input int s, input int e, input int st, input int set, input int dw);
    @(posedge clk); #2;
    thrStart = 12'(s); thrStop = 12'(e); thrStep = 11'(st);
    settleCycles = 8'(set); dwellCycles = 24'(dw);
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    scrambleConfig();
  endtask

  task automatic waitIdle(input int budget, input string name);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "Idle"}, int'(busy), 0);
  endtask

  task automatic pulseAbort();
    @(posedge clk); #2;
    abort = 1'b1;
    @(posedge clk); #2;
    abort = 1'b0;
  endtask

  initial begin
    #600000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    compareOn = 1;
    checkOutput("rstThreshold", int'(threshold), 0);
    checkOutput("rstBusy", int'(busy), 0);
    checkOutput("rstValid", int'(resValid), 0);
    checkOutput("rstCount", int'(resCount), 0);
    checkOutput("rstSat", int'(resSat), 0);
    @(posedge clk); #2;
    reset = 1'b1;

    // Three-point scan with periodic single-cycle trigger pulses
    $display("[TB] scan -2..2 step 2");
    trigMode = 1; readyMode = 0; resQ.delete(); doneCnt = 0;
    applyStimulus(-2, 2, 2, 3, 10);
    waitIdle(300, "s1");
    checkOutput("s1Points", resQ.size(), 3);
    if (resQ.size() >= 3) begin
      checkOutput("s1Thr0", resQ[0].thr, -2);
      checkOutput("s1Thr1", resQ[1].thr, 0);
      checkOutput("s1Thr2", resQ[2].thr, 2);
      for (int i = 0; i < 3; i++)
        checkOutput("s1CountRange", int'(resQ[i].cnt >= 2 && resQ[i].cnt <= 3), 1);
    end
    checkOutput("s1Done", doneCnt, 1);

    // Stop below start: exactly one point
    $display("[TB] scan 5..3");
    resQ.delete(); doneCnt = 0;
    applyStimulus(5, 3, 1, 1, 4);
    waitIdle(100, "s2");
    checkOutput("s2Points", resQ.size(), 1);
    if (resQ.size() >= 1) checkOutput("s2Thr0", resQ[0].thr, 5);
    checkOutput("s2Done", doneCnt, 1);

    // Top of the signed range: no wrap past 2047
    $display("[TB] scan 2040..2047 step 5");
    resQ.delete();
    applyStimulus(2040, 2047, 5, 1, 3);
    waitIdle(100, "s3");
    checkOutput("s3Points", resQ.size(), 2);
    if (resQ.size() >= 2) begin
      checkOutput("s3Thr0", resQ[0].thr, 2040);
      checkOutput("s3Thr1", resQ[1].thr, 2045);
    end
    checkOutput("s3HoldThr", int'($signed(threshold)), 2045);

    // Backpressure: the model tracks stability and that waiting pulses are not counted
    $display("[TB] backpressure");
    resQ.delete(); readyMode = 1;
    applyStimulus(0, 1, 1, 2, 8);
    n = 0;
    while (!resValid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("bpValid", int'(resValid), 1);
    repeat (20) @(negedge clk);
    readyMode = 0;
    waitIdle(200, "bp");
    checkOutput("bpPoints", resQ.size(), 2);

    // Saturation: toggling trigger gives 32 edges in 64 cycles
    $display("[TB] saturation");
    resQ.delete(); trigMode = 2;
    applyStimulus(0, 0, 1, 0, 64);
    waitIdle(200, "sat");
    if (resQ.size() >= 1) begin
      checkOutput("satCount16", resQ[0].cnt, 32);
      checkOutput("satFlag16", resQ[0].sat, 0);
      checkOutput("satCount4", resQ[0].cntB, 15);
      checkOutput("satFlag4", resQ[0].satB, 1);
    end else begin
      checkOutput("satPoints", resQ.size(), 1);
    end

    // Abort mid-dwell, start+abort together in idle, then reset during settle
    $display("[TB] abort and reset");
    trigMode = 3; doneCnt = 0;
    applyStimulus(-5, 5, 1, 2, 30);
    repeat (10) @(posedge clk);
    pulseAbort();
    @(negedge clk);
    checkOutput("abBusy", int'(busy), 0);
    checkOutput("abValid", int'(resValid), 0);
    checkOutput("abThr", int'($signed(threshold)), -5);
    checkOutput("abDone", doneCnt, 0);
    @(posedge clk); #2;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #2;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    checkOutput("startAbortBusy", int'(busy), 0);
    applyStimulus(3, 9, 2, 50, 5);
    repeat (10) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    checkOutput("rst2Threshold", int'(threshold), 0);
    checkOutput("rst2Busy", int'(busy), 0);
    checkOutput("rst2Done", int'(done), 0);
    checkOutput("rst2Valid", int'(resValid), 0);
    checkOutput("rst2ResThr", int'(resThreshold), 0);
    checkOutput("rst2Count", int'(resCount), 0);
    checkOutput("rst2Sat", int'(resSat), 0);
    checkOutput("rst2ThresholdB", int'(thresholdB), 0);
    checkOutput("rst2NoDone", doneCnt, 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;

    // Randomized scans with random ready, triggers, starts and aborts
    $display("[TB] random phase");
    readyMode = 2; trigMode = 3;
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk); #2;
      scrambleConfig();
      start = ($urandom_range(0, 29) == 0);
      abort = ($urandom_range(0, 199) == 0);
    end
    @(posedge clk); #2;
    start = 1'b0; abort = 1'b0; readyMode = 0;
    waitIdle(3000, "rand");
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/threshold_scan_sequencer.md
# threshold_scan_sequencer

Automatic threshold-scan (S-curve) sequencer for the particle-detector trigger path. It drives the signed discriminator threshold from a start value to a stop value in fixed steps. At each step it waits a settling time, then counts discriminator trigger pulses over a programmable dwell window. Each (threshold, count) result goes out over a valid/ready stream to the readout/UART logic. It sits beside the manual threshold controller; a top-level mux selects which one drives the threshold DAC/comparator.

## Interface
- N_P, 12, threshold width (signed two's complement)
- DWELL_W, 24, dwell counter width
- CNT_W, 16, trigger counter width
- SET_W, 8, settle counter width

- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  single-cycle scan start request
- abort  in  1  single-cycle abort request
- thr_start  in  N_P  first threshold (signed)
- thr_stop  in  N_P  last threshold bound (signed)
- thr_step  in  N_P-1  step size (unsigned; 0 treated as 1)
- settle_cycles  in  SET_W  cycles ignored after each threshold change
- dwell_cycles  in  DWELL_W  counting window length (0 treated as 1)
- trigger  in  1  discriminator output, synchronous to clk, level
- threshold  out  N_P  threshold driven to datapath (signed)
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse on normal scan completion
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_threshold  out  N_P  threshold of this result
- res_count  out  CNT_W  trigger rising edges counted
- res_sat  out  1  res_count saturated

## Operation
- States: IDLE, SETTLE, DWELL, REPORT, DONE.
- IDLE: on start, latch all config inputs; threshold <= thr_start; busy <= 1. If the latched settle count is nonzero, go to SETTLE; otherwise go directly to DWELL. Config inputs are ignored while busy.
- SETTLE: lasts exactly settle_cycles cycles; triggers are not counted. Then go to DWELL with the trigger counter cleared.
- DWELL: lasts exactly max(dwell_cycles,1) cycles. In each cycle, count a rising edge (trigger & ~trigger_q). trigger_q is registered every cycle in every state and resets to 0. The counter saturates at 2^CNT_W-1 and sets the sat flag. Then go to REPORT.
- REPORT: res_valid=1, with res_threshold/res_count/res_sat held stable until the handshake (res_valid & res_ready at a clock edge). On handshake, compute next = threshold + step in N_P+1-bit signed arithmetic:
  - If next > thr_stop, or next > 2^(N_P-1)-1, go to DONE.
  - Otherwise threshold <= next[N_P-1:0] and go to SETTLE (or DWELL if settle is 0).
- DONE: done=1 for one cycle, busy <= 0, then IDLE. threshold holds its last value until the next start.
- thr_stop < thr_start: exactly one point is measured (at thr_start).
- abort: from any non-IDLE state, go to IDLE at the next edge; res_valid and busy drop, and done is not pulsed. Abort has priority over a simultaneous handshake. Abort in IDLE has no effect. Start and abort asserted together in IDLE: abort wins and no scan starts.
- Reset (asynchronous, any time): state=IDLE; threshold=0, busy=0, done=0, res_valid=0, res_threshold=0, res_count=0, res_sat=0; all internal counters and trigger_q = 0.

## Timing
- start sampled at edge E0: busy=1 and threshold=thr_start are visible after E0.
- With S = settle_cycles and D = dwell_cycles, res_valid rises after edge E0+S+D.
- A trigger rising edge is counted only if its first high cycle falls within the D DWELL cycles. A trigger already high when DWELL begins is counted only if it was low in the previous cycle.
- Handshake at edge H: res_valid drops after H. The new threshold is visible after H, and the next result is valid after H+S+D. Zero-wait consumer per-point period: S+D+1 cycles.
- Last handshake at H: done=1 in cycle H+1 only; busy=0 after H+1.
- Backpressure: REPORT waits indefinitely; counting is suspended and trigger edges during REPORT are not accumulated.

## Test plan
- thr_start=-2, thr_stop=2, step=2, settle=3, dwell=10, trigger 1-cycle pulses every 4 cycles, res_ready=1 -> three results: thresholds -2, 0, 2; each count 2 or 3 matching the model; done pulses once; busy clears.
- thr_start=5, thr_stop=3 -> single result at threshold 5, then done.
- thr_start=2040, thr_stop=2047, step=5 -> results at 2040 and 2045 only (2050 exceeds both bound and range); no wrap to negative.
- res_ready held low for 20 cycles in REPORT -> res_valid/res_threshold/res_count stable; trigger pulses during the wait are not counted toward the next point.
- CNT_W=4, trigger toggling every cycle, dwell=64 -> res_count=15, res_sat=1.
- abort asserted mid-DWELL, then reset deasserted/asserted mid-SETTLE in a second scan -> IDLE, busy=0, no done, res_valid=0; after reset all outputs 0.
